// File: rtl/frame_swap_ctrl.sv
// Double-buffered frame controller: a producer fills the back buffer while the
// display streams the front buffer; the buffers swap when the display wraps.
module frame_swap_ctrl #(
  parameter int FRAME_WORDS = 2048,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [23:0]       wr_data,
  output logic              wr_ready,
  input  logic              px_req,
  output logic [23:0]       px_data,
  output logic              px_valid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_change,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        frame_count,
  output logic [7:0]        repeat_count
);

  localparam int STAGES = 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {FILL, WAIT_SWAP, SWAP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q, mem_addr_q;
  logic [23:0]         mem_wdata_q, px_data_q;
  logic [STAGES:0]     vld_pipe_q;  // [0]: read issued to memory, [1]: word returned
  logic                mem_wr_q, mem_change_q;
  logic [7:0]          frame_count_q, repeat_count_q;
  logic                wr_acc, rd_wrap;

  // Display always wins the single memory port.
  assign wr_ready = (state_q == FILL) && !px_req && !rst;
  assign wr_acc   = wr_valid && wr_ready;
  assign rd_wrap  = px_req && (rd_addr_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FILL;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      px_data_q      <= '0;
      vld_pipe_q     <= '0;
      mem_wr_q       <= 1'b0;
      mem_change_q   <= 1'b0;
      frame_count_q  <= '0;
      repeat_count_q <= '0;
    end else begin
      vld_pipe_q   <= {vld_pipe_q[STAGES-1:0], px_req};
      mem_wr_q     <= wr_acc;
      mem_change_q <= 1'b0;
      if (px_req) begin
        mem_addr_q <= rd_addr_q;
        rd_addr_q  <= rd_wrap ? '0 : rd_addr_q + 1'b1;
      end else if (wr_acc) begin
        mem_addr_q  <= wr_addr_q;
        mem_wdata_q <= wr_data;
      end
      if (vld_pipe_q[0]) px_data_q <= mem_rdata;
      case (state_q)
        FILL: begin
          if (wr_acc) begin
            if (wr_addr_q == LAST) state_q <= WAIT_SWAP;
            else                   wr_addr_q <= wr_addr_q + 1'b1;
          end
          // Reader lapped the writer: the old front frame is shown again.
          if (rd_wrap && repeat_count_q != 8'hFF) repeat_count_q <= repeat_count_q + 1'b1;
        end
        WAIT_SWAP: if (rd_wrap) begin
          state_q      <= SWAP;
          mem_change_q <= 1'b1;
        end
        SWAP: begin
          wr_addr_q     <= '0;
          frame_count_q <= frame_count_q + 1'b1;
          state_q       <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign mem_rd       = vld_pipe_q[0];
  assign px_valid     = vld_pipe_q[STAGES];
  assign px_data      = px_data_q;
  assign mem_wr       = mem_wr_q;
  assign mem_change   = mem_change_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign frame_count  = frame_count_q;
  assign repeat_count = repeat_count_q;

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Bench for frame_swap_ctrl: double-buffered memory model plus a frame-level
// reference model, driven by directed phases and random traffic.
module tb_frame_swap_ctrl;
  localparam int FW = 2048;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0, px_req = 1'b0;
  logic [23:0]   wr_data = '0;
  logic          wr_ready, px_valid, mem_rd, mem_wr, mem_change;
  logic [23:0]   px_data, mem_wdata;
  logic [23:0]   mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    frame_count, repeat_count;

  frame_swap_ctrl #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .px_req(px_req), .px_data(px_data), .px_valid(px_valid), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_change(mem_change), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .frame_count(frame_count), .repeat_count(repeat_count));

  always #5 clk = ~clk;

  // Two-bank memory: reads use the select in force during the cycle, swap afterwards.
  logic [23:0] bank0 [FW] = '{default: '0};
  logic [23:0] bank1 [FW] = '{default: '0};
  logic        sel = 1'b0;
  always @(negedge clk) begin
    if (mem_wr) begin
      if (sel) bank0[mem_addr] <= mem_wdata;
      else     bank1[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= sel ? bank1[mem_addr] : bank0[mem_addr];
    if (mem_change) sel <= ~sel;
  end

  // Frame-level reference model.
  logic [23:0] m_front [FW] = '{default: '0};
  logic [23:0] m_back  [FW] = '{default: '0};
  int          m_filled, m_rd, m_fc, m_rc;
  bit          m_swap, pend_v;
  logic [23:0] pend_d, last_px;
  int          npass = 0, ntot = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_filled = 0; m_rd = 0; m_fc = 0; m_rc = 0;
    m_swap = 0; pend_v = 0; pend_d = '0; last_px = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wr_ready"}, wr_ready, 0);
    chk({tag, ".mem_rd"}, mem_rd, 0);
    chk({tag, ".mem_wr"}, mem_wr, 0);
    chk({tag, ".mem_change"}, mem_change, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".px_data"}, px_data, 0);
    chk({tag, ".px_valid"}, px_valid, 0);
    chk({tag, ".frame_count"}, frame_count, 0);
    chk({tag, ".repeat_count"}, repeat_count, 0);
  endtask

  // One clock of traffic: drive, check ready, clock, check registered outputs.
  task automatic step(input bit req, input bit wv);
    logic [23:0] wd, nd, tmp;
    bit          exp_rdy, wacc, chg;
    wd = 24'($urandom);
    nd = '0;
    px_req = req; wr_valid = wv; wr_data = wd;
    #1;
    exp_rdy = !req && (m_filled < FW) && !m_swap;
    chk("wr_ready", wr_ready, exp_rdy);
    wacc = wv && exp_rdy;
    chg  = req && (m_rd == FW - 1) && (m_filled == FW) && !m_swap;
    @(posedge clk); #1;
    chk("mem_rd", mem_rd, req);
    chk("mem_wr", mem_wr, wacc);
    chk("mem_change", mem_change, chg);
    if (req)       chk("rd_addr", mem_addr, m_rd);
    else if (wacc) chk("wr_addr", mem_addr, m_filled);
    if (wacc)      chk("mem_wdata", mem_wdata, wd);
    chk("px_valid", px_valid, pend_v);
    chk("px_data", px_data, pend_v ? pend_d : last_px);
    if (pend_v) last_px = pend_d;
    if (m_swap) begin
      m_fc = (m_fc + 1) % 256; m_filled = 0; m_swap = 0;
    end
    if (req) begin
      nd = m_front[m_rd];
      if (m_rd == FW - 1) begin
        m_rd = 0;
        if (chg) begin
          for (int i = 0; i < FW; i++) begin
            tmp = m_front[i]; m_front[i] = m_back[i]; m_back[i] = tmp;
          end
          m_swap = 1;
        end else if (m_rc < 255) m_rc++;
      end else m_rd++;
    end
    if (wacc) begin
      m_back[m_filled] = wd; m_filled++;
    end
    pend_v = req; pend_d = nd;
    chk("frame_count", frame_count, m_fc);
    chk("repeat_count", repeat_count, m_rc);
  endtask

  task automatic do_reset();
    rst = 1'b1; px_req = 1'b0; wr_valid = 1'b1;
    #1;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    // Full frame with no display traffic, then idle in WAIT_SWAP.
    repeat (FW) step(0, 1);
    repeat (3) step(0, 0);
    repeat (3) step(0, 1);
    // Continuous display requests through the swap and into the new frame.
    repeat (FW + 4) step(1, 1);
    // Partial frame, reader laps it: repeat, no swap, writing resumes at 100.
    repeat (100) step(0, 1);
    repeat (FW - 4) step(1, 0);
    repeat (5) step(0, 1);
    // Contention: read wins, stalled write completes next cycle.
    step(1, 1);
    step(0, 1);
    // Random mixed traffic.
    repeat (12000) step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 8);
    // Reset mid-frame at write address 500.
    do_reset();
    repeat (500) step(0, 1);
    #3 rst = 1'b1;
    #1 chk_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(0, 1);
    step(0, 1);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/frame_swap_ctrl.md
FRAME_SWAP_CTRL -- requirements
Module: frame_swap_ctrl

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 2048, words per frame (range 2..2048).
REQ-002 SHALL have parameter ADDR_W, default 12, width of the memory address.
REQ-003 SHALL have port clk, input, 1, the single clock; all controller state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1, producer offers a pixel word.
REQ-006 SHALL have port wr_data, input, 24, producer pixel word.
REQ-007 SHALL have port wr_ready, output, 1, word accepted when wr_valid and wr_ready are both high at a rising edge.
REQ-008 SHALL have port px_req, input, 1, display requests the next front-buffer word.
REQ-009 SHALL have port px_data, output, 24, returned display word.
REQ-010 SHALL have port px_valid, output, 1, px_data is valid this cycle.
REQ-011 SHALL have port mem_rd, output, 1, drives the memory read strobe.
REQ-012 SHALL have port mem_wr, output, 1, drives the memory write strobe.
REQ-013 SHALL have port mem_change, output, 1, drives the memory buffer-swap strobe.
REQ-014 SHALL have port mem_addr, output, ADDR_W, drives the memory address.
REQ-015 SHALL have port mem_wdata, output, 24, drives the memory write data.
REQ-016 SHALL have port mem_rdata, input, 24, memory read data, updated on falling clk edge.
REQ-017 SHALL have port frame_count, output, 8, count of completed swaps, wraps 255->0.
REQ-018 SHALL have port repeat_count, output, 8, count of frames re-displayed without a swap, saturates at 255.

Function
REQ-019 SHALL use states FILL, WAIT_SWAP and SWAP.
REQ-020 SHALL register all mem_* outputs, so one granted operation occupies exactly one clk cycle.
REQ-021 SHALL give the display priority: wr_ready = (state==FILL) && !px_req, combinational.
REQ-022 SHALL, on an accepted px_req, drive mem_rd=1 and mem_addr=rd_addr in the next cycle, then increment rd_addr.
REQ-023 SHALL capture mem_rdata into px_data with px_valid=1 one cycle after the mem_rd cycle (2-edge latency from sampled px_req); otherwise px_valid=0 and px_data holds.
REQ-024 SHALL, on an accepted write, drive mem_wr=1, mem_addr=wr_addr and mem_wdata=wr_data in the next cycle, then increment wr_addr.
REQ-025 SHALL never assert mem_rd and mem_wr in the same cycle.
REQ-026 SHALL move FILL->WAIT_SWAP on the write accepted at wr_addr==FRAME_WORDS-1; wr_addr then holds and wr_ready stays 0.
REQ-027 SHALL wrap rd_addr from FRAME_WORDS-1 to 0 on the read accepted at the last address (rd_wrap event).
REQ-028 SHALL increment repeat_count on rd_wrap in state FILL, because the old front frame is shown again.
REQ-029 SHALL move WAIT_SWAP->SWAP on rd_wrap, setting mem_change=1 at that edge alongside the final mem_rd.
REQ-030 SHALL rely on the memory reading with the pre-swap select in that cycle, so the final word comes from the old front buffer.
REQ-031 SHALL, in SWAP, clear mem_change at the next edge, reset wr_addr to 0, increment frame_count and return to FILL; this gives exactly one mem_change pulse per swap.
REQ-032 SHALL accept px_req in SWAP normally, at address 0, which reads the new front buffer.
REQ-033 SHALL, in WAIT_SWAP with no px_req, hold indefinitely with no memory activity.

Reset
REQ-034 SHALL, while rst is high, force state=FILL, wr_addr=rd_addr=0, mem_rd=mem_wr=mem_change=0, mem_addr=0, mem_wdata=0, px_data=0, px_valid=0, frame_count=0, repeat_count=0; wr_ready=0 while rst is high.
REQ-035 SHALL abandon any partial frame on reset mid-operation, and the next frame SHALL restart at address 0; the memory bank select is not reset and needs no known value.

Verification
REQ-036 Reset then 2048 back-to-back writes with px_req=0 -> mem_wr pulses for addresses 0..2047 with data matching, state WAIT_SWAP, wr_ready=0.
REQ-037 px_req held high continuously -> mem_rd every cycle at addresses 0,1,2,...; px_valid high 2 edges after the first sampled request; wr_ready=0 throughout.
REQ-038 Full frame written, then reads reach address 2047 -> mem_change high for exactly 1 cycle coincident with the read of address 2047; frame_count 0->1; next read at address 0 returns the newly written data.
REQ-039 Reader wraps while only 100 words written -> repeat_count=1, no mem_change, and writing continues from address 100.
REQ-040 wr_valid and px_req both high in the same cycle -> read granted, write stalled; the write completes in the first cycle px_req is low.
REQ-041 rst asserted mid-frame at wr_addr=500 -> all outputs 0 immediately, with no clock edge needed; after release the first write goes to address 0.
